// File: rtl/din_syn_pkg.sv
// Shared types and helpers for the DIN/SYN serializer: FSM state encoding
// and the bit-counter width rule.
package din_syn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SYNC  = 2'd2
  } state_e;

  // The counter also has to hold index NBITS, which is the SYNC slot.
  function automatic int cnt_width(input int nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/sclk_div.sv
// Serial clock divider: sclk half-period is div+1 clk_in cycles. The strobes
// flag the cycle just before sclk rises or falls.
module sclk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             half_end;

  always_comb begin
    half_end = (cnt_q == div);
    rise_stb = run & half_end & ~sclk_q;
    fall_stb = run & half_end & sclk_q;
    cnt_d    = cnt_q + DIV_W'(1);
    sclk_d   = sclk_q;
    if (!run) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (half_end) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/din_syn_serializer.sv
// Multi-lane DIN/SYN frame serializer: snapshots a pattern on a trig edge and
// shifts it out with a divided serial clock, a SYN slot and repeat support.
module din_syn_serializer
  import din_syn_pkg::*;
#(
  parameter int NBITS = 626,
  parameter int NCH   = 1,
  parameter int DIV_W = 8,
  parameter int REP_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [NCH*NBITS-1:0] data_reg,
  input  logic                 trig,
  input  logic                 abort,
  input  logic                 clr_mode,
  input  logic                 clr_2_one,
  input  logic                 msb_first,
  input  logic [DIV_W-1:0]     div,
  input  logic [REP_W-1:0]     repeat_n,
  output logic                 sclk,
  output logic [NCH-1:0]       din,
  output logic                 syn,
  output logic                 out_en,
  output logic                 sclk_oe,
  output logic                 busy,
  output logic                 done
);

  localparam int               BIT_W    = cnt_width(NBITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);

  state_e               state_q, state_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [REP_W-1:0]     frm_q, frm_d;
  logic                 done_q, done_d;
  logic [NCH-1:0]       din_q, din_d;
  logic [NCH-1:0]       nxt_q, nxt_d;
  logic [BIT_W-1:0]     nxt_idx;
  logic                 trig_arm_q;
  logic                 trig_edge;
  logic                 start;

  logic [NCH*NBITS-1:0] data_q;
  logic                 clr_q;
  logic                 one_q;
  logic                 msb_q;
  logic [DIV_W-1:0]     div_q;
  logic [REP_W-1:0]     rep_q;

  logic                 run;
  logic                 rise_stb;
  logic                 fall_stb;

  // Lane mux: one bit per lane at transmit index idx (idx < NBITS).
  function automatic logic [NCH-1:0] pick_bits(
    input logic [NCH*NBITS-1:0] d,
    input logic                 clr,
    input logic                 one,
    input logic                 msb,
    input logic [BIT_W-1:0]     idx
  );
    logic [BIT_W-1:0] k;
    logic [NCH-1:0]   r;
    k = msb ? (LAST_BIT - idx) : idx;
    for (int c = 0; c < NCH; c++) begin
      r[c] = clr ? one : d[c*NBITS + int'(k)];
    end
    return r;
  endfunction

  // trig_arm_q is set once trig has been seen low; reset clears it so a
  // trig held high across reset release cannot start a sequence.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      trig_arm_q <= 1'b0;
    end else begin
      trig_arm_q <= ~trig;
    end
  end

  assign trig_edge = trig & trig_arm_q;
  assign start     = (state_q == IDLE) && trig_edge && !abort;
  assign run       = (state_q != IDLE) && !abort;

  sclk_div #(
    .DIV_W (DIV_W)
  ) u_sclk_div (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .run      (run),
    .div      (div_q),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (trig_edge) state_d = SHIFT;
        SHIFT:   if (fall_stb && (bit_q == LAST_BIT)) state_d = SYNC;
        SYNC:    if (fall_stb) state_d = (frm_q == rep_q) ? IDLE : SHIFT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    out_en  = 1'b0;
    sclk_oe = 1'b0;
    syn     = 1'b0;
    if (state_q != IDLE) begin
      busy    = 1'b1;
      out_en  = 1'b1;
      sclk_oe = 1'b1;
    end
    if ((state_q == SYNC) && !clr_q) begin
      syn = 1'b1;
    end
  end

  assign din  = din_q;
  assign done = done_q;

  // The next lane value is looked up on the sclk rise so din_q only has to
  // load it on the falling strobe; the wide lane mux stays off the pad path.
  always_comb begin
    nxt_idx = '0;
    nxt_d   = nxt_q;
    if ((state_q == SHIFT) && (bit_q != LAST_BIT)) begin
      nxt_idx = bit_q + BIT_W'(1);
    end
    if (rise_stb) begin
      if ((state_q == SHIFT) && (bit_q == LAST_BIT)) begin
        nxt_d = {NCH{clr_q & one_q}};
      end else begin
        nxt_d = pick_bits(data_q, clr_q, one_q, msb_q, nxt_idx);
      end
    end
  end

  always_comb begin
    bit_d  = bit_q;
    frm_d  = frm_q;
    din_d  = din_q;
    done_d = 1'b0;
    if (state_d == IDLE) begin
      bit_d  = '0;
      frm_d  = '0;
      din_d  = '0;
      done_d = (state_q == SYNC) && fall_stb && !abort;
    end else if (start) begin
      bit_d = '0;
      frm_d = '0;
      din_d = pick_bits(data_reg, clr_mode, clr_2_one, msb_first, '0);
    end else if (fall_stb) begin
      din_d = nxt_q;
      if (state_q == SHIFT) begin
        bit_d = bit_q + BIT_W'(1);
      end else begin
        bit_d = '0;
        frm_d = frm_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      bit_q  <= '0;
      frm_q  <= '0;
      din_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bit_q  <= bit_d;
      frm_q  <= frm_d;
      din_q  <= din_d;
      done_q <= done_d;
    end
  end

  // Shadow copies of the configuration, frozen for the whole sequence.
  always_ff @(posedge clk_in) begin
    if (start) begin
      data_q <= data_reg;
      clr_q  <= clr_mode;
      one_q  <= clr_2_one;
      msb_q  <= msb_first;
      div_q  <= div;
      rep_q  <= repeat_n;
    end
    nxt_q <= nxt_d;
  end

endmodule

// File: tb/tb_din_syn_serializer.sv
// Directed bench for din_syn_serializer with NBITS=8, NCH=2.
module tb_din_syn_serializer;

  localparam int NB = 8;
  localparam int NC = 2;
  localparam int DW = 8;
  localparam int RW = 8;

  logic           clk_in    = 1'b0;
  logic           rst_n     = 1'b0;
  logic [NC*NB-1:0] data_reg = '0;
  logic           trig      = 1'b0;
  logic           abort     = 1'b0;
  logic           clr_mode  = 1'b0;
  logic           clr_2_one = 1'b0;
  logic           msb_first = 1'b0;
  logic [DW-1:0]  div       = '0;
  logic [RW-1:0]  repeat_n  = '0;
  logic           sclk;
  logic [NC-1:0]  din;
  logic           syn;
  logic           out_en;
  logic           sclk_oe;
  logic           busy;
  logic           done;

  int checks   = 0;
  int failures = 0;

  din_syn_serializer #(
    .NBITS (NB),
    .NCH   (NC),
    .DIV_W (DW),
    .REP_W (RW)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .data_reg  (data_reg),
    .trig      (trig),
    .abort     (abort),
    .clr_mode  (clr_mode),
    .clr_2_one (clr_2_one),
    .msb_first (msb_first),
    .div       (div),
    .repeat_n  (repeat_n),
    .sclk      (sclk),
    .din       (din),
    .syn       (syn),
    .out_en    (out_en),
    .sclk_oe   (sclk_oe),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    check(tag, {25'd0, sclk, din, syn, out_en, sclk_oe, busy, done}, 32'd0);
  endtask

  // e0/e1 list lane bits in transmit order, first bit at [7].
  task automatic run_seq(input string tag, input int dv, input int rp,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic esyn, input logic sdin, input bit poke);
    int p, total, b, pos;
    logic [NC-1:0] edin;
    p     = 2 * (dv + 1);
    total = (rp + 1) * (NB + 1) * p;
    @(posedge clk_in); #1 trig = 1'b1;
    @(posedge clk_in); #1 trig = 1'b0;
    for (int m = 0; m < total; m++) begin
      if (poke && m == 3) data_reg = ~data_reg;
      if (poke && m == 5) trig = 1'b1;
      if (poke && m == 7) trig = 1'b0;
      @(negedge clk_in);
      b   = (m / p) % (NB + 1);
      pos = m % p;
      if (b == NB) edin = {NC{sdin}};
      else         edin = {e1[7-b], e0[7-b]};
      check({tag, "_en"},   {busy, out_en, sclk_oe}, 3'b111);
      check({tag, "_sclk"}, sclk, (pos > dv));
      check({tag, "_syn"},  syn, (b == NB) ? esyn : 1'b0);
      check({tag, "_din"},  din, edin);
      check({tag, "_done"}, done, 1'b0);
      @(posedge clk_in); #1;
    end
    @(negedge clk_in);
    check({tag, "_done_pulse"}, done, 1'b1);
    check({tag, "_end_idle"}, {26'd0, sclk, din, syn, out_en, sclk_oe, busy}, 32'd0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check({tag, "_done_clear"}, done, 1'b0);
    check({tag, "_busy_clear"}, busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    repeat (3) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    idle_chk("reset_outputs");
    @(posedge clk_in); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    // lane0 A5 LSB first, pattern changed mid-frame, ignored retrigger
    data_reg = {8'h00, 8'hA5};
    div = 8'd0; repeat_n = '0; msb_first = 1'b0;
    run_seq("t1", 0, 0, 8'b10100101, 8'b00000000, 1'b1, 1'b0, 1'b1);

    data_reg = 16'h3CA5; div = 8'd3; msb_first = 1'b1;
    run_seq("t2", 3, 0, 8'b10100101, 8'b00111100, 1'b1, 1'b0, 1'b0);

    data_reg = 16'h3CA5; div = 8'd0; msb_first = 1'b0; repeat_n = 8'd2;
    run_seq("t3", 0, 2, 8'b10100101, 8'b00111100, 1'b1, 1'b0, 1'b1);

    repeat_n = '0; data_reg = 16'h1234; clr_mode = 1'b1; clr_2_one = 1'b1;
    run_seq("clr1", 0, 0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    clr_2_one = 1'b0; data_reg = 16'hFFFF;
    run_seq("clr0", 0, 0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    clr_mode = 1'b0;

    // abort at bit 3
    data_reg = 16'h3CA5; div = 8'd0; msb_first = 1'b0;
    @(posedge clk_in); #1 trig = 1'b1;
    @(posedge clk_in); #1 trig = 1'b0;
    repeat (6) @(posedge clk_in);
    #1 abort = 1'b1;
    @(negedge clk_in);
    check("abort_pre_busy", busy, 1'b1);
    check("abort_pre_din", din, 2'b10);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    idle_chk("abort_idle");
    @(posedge clk_in); #1 abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_in);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);

    // abort coincident with a trig edge
    @(posedge clk_in); #1 trig = 1'b1; abort = 1'b1;
    @(posedge clk_in); #1 trig = 1'b0; abort = 1'b0;
    @(negedge clk_in);
    idle_chk("abort_trig_idle");
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("abort_trig_nostart", busy, 1'b0);

    // reset at bit 5 with trig held high through release
    @(posedge clk_in); #1 trig = 1'b1;
    @(posedge clk_in); #1 trig = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check("rst_pre_busy", busy, 1'b1);
    @(posedge clk_in); #1 rst_n = 1'b0; trig = 1'b1;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    idle_chk("rst_idle");
    @(posedge clk_in); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    idle_chk("rst_trig_held");
    @(posedge clk_in); #1 trig = 1'b0;
    @(posedge clk_in); #1 trig = 1'b1;
    @(posedge clk_in); #1 trig = 1'b0;
    @(negedge clk_in);
    check("rst_fresh_busy", busy, 1'b1);
    check("rst_fresh_din", din, 2'b01);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_in);
      if (done) seen = 1'b1;
    end
    check("rst_fresh_done", seen, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
